// File: rtl/audio_fifo_bridge.sv
// audio_fifo_bridge: sample stream in, CPU-popped FIFO out through a
// four-register slave (DATA, STATUS, CTRL, CLEAR). Provides a watermark
// interrupt, sticky overflow/underflow flags and a software flush.
module audio_fifo_bridge #(
  parameter int DATA_SIZE  = 28,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WM_RESET   = DEPTH / 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 chipselect_i,
  input  logic [1:0]           address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [31:0]          write_data_i,
  output logic [31:0]          read_data_o,
  input  logic                 source_valid_i,
  input  logic [DATA_SIZE-1:0] source_data_i,
  output logic [1:0]           source_ready_o,
  output logic                 irq_o
);

  localparam int              LW       = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0]   WM_RST_L = LW'(WM_RESET);
  localparam logic [15:0]     DEPTH_16 = 16'(DEPTH);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_CLEAR  = 2'd3;

  logic [DATA_SIZE-1:0]  mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         wm_q, wm_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [31:0]           read_data_q, read_data_d;

  logic        empty, full;
  logic        rd, wr, wr_ctrl, wr_clr, flush, push, pop;
  logic [15:0] wm_req;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^write_data_i[31:17];

  // Flow-control view derived from the registered level only.
  assign empty          = (level_q == '0);
  assign full           = (level_q == DEPTH_L);
  assign source_ready_o = {2{~full}};
  assign read_data_o    = read_data_q;
  assign irq_o          = irq_q;

  // Bus decode: a read in the same cycle as a write suppresses the write.
  assign rd      = chipselect_i & read_i;
  assign wr      = chipselect_i & write_i & ~rd;
  assign wr_ctrl = wr & (address_i == A_CTRL);
  assign wr_clr  = wr & (address_i == A_CLEAR);
  assign flush   = wr_clr & write_data_i[2];
  assign push    = source_valid_i & ~full & ~flush;
  assign pop     = rd & (address_i == A_DATA) & ~empty;
  assign wm_req  = write_data_i[15:0];

  // STATUS register image.
  always_comb begin
    status            = '0;
    status[LW-1:0]    = level_q;
    status[16]        = empty;
    status[17]        = full;
    status[18]        = (level_q >= wm_q);
    status[19]        = ovf_q;
    status[20]        = udf_q;
    status[24]        = irq_en_q;
  end

  // Next-state for pointers, level, flags, control and the read port.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wm_d        = wm_q;
    irq_en_d    = irq_en_q;
    read_data_d = read_data_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end

    // A clear and a new event in the same cycle: the new event wins.
    ovf_d = (ovf_q & ~(wr_clr & write_data_i[0])) | (source_valid_i & full);
    udf_d = (udf_q & ~(wr_clr & write_data_i[1])) | (rd & (address_i == A_DATA) & empty);

    if (wr_ctrl) begin
      irq_en_d = write_data_i[16];
      if (wm_req == 16'd0)          wm_d = LW'(1);
      else if (wm_req > DEPTH_16)   wm_d = DEPTH_L;
      else                          wm_d = wm_req[LW-1:0];
    end

    if (rd) begin
      read_data_d = '0;
      case (address_i)
        A_DATA:   if (!empty) read_data_d[DATA_SIZE-1:0] = mem[rd_ptr_q];
        A_STATUS: read_data_d = status;
        A_CTRL:   begin
          read_data_d[LW-1:0] = wm_q;
          read_data_d[16]     = irq_en_q;
        end
        default:  read_data_d = '0;
      endcase
    end

    irq_d = irq_en_d & ((level_d >= wm_d) | ovf_d);
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= source_data_i;
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wm_q        <= WM_RST_L;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wm_q        <= wm_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      read_data_q <= read_data_d;
    end
  end

endmodule
